// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types and constants for the transmit master and receive slave
package spi_pkg;
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;
    function automatic int bit_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with registered level and rise/fall detect
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] s;
    logic q;
    logic p;
    // synchronizer chain, edge-detect register and its previous value
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= {SYNC_STAGES{RST_VAL}};
            q <= RST_VAL;
            p <= RST_VAL;
        end else begin
            s <= {s[SYNC_STAGES-2:0], d};
            q <= s[SYNC_STAGES-1];
            p <= q;
        end
    end
    assign level = q;
    assign rise = q & ~p;
    assign fall = ~q & p;
endmodule

// File: rtl/tspi_rx_slave.sv
// tspi_rx_slave: SPI mode-0 receive deserializer with valid/ready output register
module tspi_rx_slave #(
    parameter int SPI0_0 = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CSN,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              rx_valid,
    output logic [SPI0_0-1:0] rx_data,
    input  logic              rx_ready,
    output logic              rx_busy,
    output logic              rx_ovf,
    output logic              rx_frame_err
);
    import spi_pkg::*;
    localparam int CW = bit_cnt_w(SPI0_0);
    localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);
    state_t state, state_nx;
    logic [SPI0_0-1:0] sr, sr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] settle;
    logic csn, csn_rise, csn_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall_unused;
    logic mosi, mosi_rise_unused, mosi_fall_unused;
    logic shift, complete, load;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
        .clk(clk), .rst(rst), .d(CSN), .level(csn), .rise(csn_rise), .fall(csn_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(SCLK), .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(MOSI), .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else state <= state_nx;
    end

    // next state, shift datapath and word-completion decode
    always_comb begin
        state_nx = state;
        shift = (state == SHIFT) && sclk_rise;
        complete = shift && (cnt == CW'(SPI0_0 - 1));
        load = complete && (!rx_valid || rx_ready);
        sr_nx = !shift ? sr : (MSB_FIRST != 0) ? {sr[SPI0_0-2:0], mosi} : {mosi, sr[SPI0_0-1:1]};
        cnt_nx = complete ? '0 : shift ? cnt + 1'b1 : cnt;
        case (state)
            WAIT_IDLE: state_nx = (csn && settle == SETTLE) ? IDLE : WAIT_IDLE;
            IDLE:      state_nx = csn_fall ? SHIFT : IDLE;
            SHIFT:     state_nx = csn_rise ? IDLE : SHIFT;
            default:   state_nx = WAIT_IDLE;
        endcase
    end

    // shift register, bit counter, output register and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
            cnt <= '0;
            settle <= '0;
            rx_valid <= 1'b0;
            rx_data <= '0;
            rx_ovf <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            settle <= (settle != SETTLE) ? settle + 3'd1 : settle;
            sr <= (state == IDLE && csn_fall) ? '0 : sr_nx;
            cnt <= (state == IDLE && csn_fall) ? '0 : cnt_nx;
            rx_valid <= complete || (rx_valid && !rx_ready);
            rx_data <= load ? sr_nx : rx_data;
            rx_ovf <= complete && rx_valid && !rx_ready;
            rx_frame_err <= (state == SHIFT) && csn_rise && (cnt_nx != '0);
        end
    end

    assign rx_busy = (state == SHIFT);
endmodule

// File: tb/tb_tspi_rx_slave.sv
// tb_tspi_rx_slave: directed self-checking bench for tspi_rx_slave (MSB- and LSB-first instances)
module tb_tspi_rx_slave;
    logic clk = 0, rst = 1, CSN = 1, SCLK = 0, MOSI = 0, rdy0 = 1, rdy1 = 1;
    logic v0, v1, b0, b1, o0, o1, f0, f1;
    logic [7:0] d0, d1;
    int errors = 0, checks = 0, cyc = 0;
    int n_ovf = 0, n_ferr = 0, t_rise = 0, t_valid = 0;
    logic vprev = 0;
    logic [7:0] q0[$], q1[$];

    typedef struct {
        string name;
        logic [7:0] data;
        int nbits;
        int exp_words;
        int exp_ferr;
    } vec_t;
    vec_t tbl[6];

    tspi_rx_slave #(.SPI0_0(8), .SYNC_STAGES(2), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .CSN(CSN), .SCLK(SCLK), .MOSI(MOSI), .rx_valid(v0), .rx_data(d0),
        .rx_ready(rdy0), .rx_busy(b0), .rx_ovf(o0), .rx_frame_err(f0)
    );
    tspi_rx_slave #(.SPI0_0(8), .SYNC_STAGES(2), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .CSN(CSN), .SCLK(SCLK), .MOSI(MOSI), .rx_valid(v1), .rx_data(d1),
        .rx_ready(rdy1), .rx_busy(b1), .rx_ovf(o1), .rx_frame_err(f1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0 && rdy0) q0.push_back(d0);
        if (v1 && rdy1) q1.push_back(d1);
        if (o0) n_ovf = n_ovf + 1;
        if (f0) n_ferr = n_ferr + 1;
        if (v0 && !vprev) t_valid = cyc;
        vprev = v0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        MOSI = b;
        tick(8);
        SCLK = 1;
        t_rise = cyc;
        tick(8);
        SCLK = 0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7-i]);
    endtask

    task automatic clear;
        q0.delete();
        q1.delete();
        n_ovf = 0;
        n_ferr = 0;
    endtask

    initial begin
        tbl[0] = '{"frame_a5", 8'hA5, 8, 1, 0};
        tbl[1] = '{"frame_00", 8'h00, 8, 1, 0};
        tbl[2] = '{"partial_ff5", 8'hFF, 5, 0, 1};
        tbl[3] = '{"frame_5a", 8'h5A, 8, 1, 0};
        tbl[4] = '{"partial_007", 8'h00, 7, 0, 1};
        tbl[5] = '{"frame_81", 8'h81, 8, 1, 0};

        tick(3);
        chk("reset_valid", v0, 0);
        chk("reset_data", d0, 0);
        chk("reset_busy", b0, 0);
        chk("reset_ovf", o0, 0);
        chk("reset_ferr", f0, 0);
        rst = 0;
        tick(10);

        for (int k = 0; k < 6; k++) begin
            clear();
            CSN = 0;
            tick(6);
            chk({tbl[k].name, "_busy"}, b0, 1);
            send_bits(tbl[k].data, tbl[k].nbits);
            tick(4);
            CSN = 1;
            tick(20);
            chk({tbl[k].name, "_busy_end"}, b0, 0);
            chk({tbl[k].name, "_words"}, q0.size(), tbl[k].exp_words);
            if (tbl[k].exp_words == 1 && q0.size() == 1) begin
                chk({tbl[k].name, "_data"}, q0[0], tbl[k].data);
                chk({tbl[k].name, "_latency"}, t_valid - t_rise, 4);
            end
            chk({tbl[k].name, "_ferr"}, n_ferr, tbl[k].exp_ferr);
            chk({tbl[k].name, "_ovf"}, n_ovf, 0);
            chk({tbl[k].name, "_valid_end"}, v0, 0);
        end

        clear();
        CSN = 0;
        tick(6);
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        tick(4);
        CSN = 1;
        tick(20);
        chk("b2b_words", q0.size(), 2);
        if (q0.size() == 2) begin
            chk("b2b_first", q0[0], 8'h3C);
            chk("b2b_second", q0[1], 8'hC3);
        end
        chk("b2b_ferr", n_ferr, 0);

        clear();
        rdy0 = 0;
        CSN = 0;
        tick(6);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        tick(4);
        CSN = 1;
        tick(20);
        chk("ovf_valid", v0, 1);
        chk("ovf_data", d0, 8'h11);
        chk("ovf_pulses", n_ovf, 1);
        rdy0 = 1;
        tick(10);
        chk("ovf_drain_words", q0.size(), 1);
        if (q0.size() == 1) chk("ovf_drain_data", q0[0], 8'h11);
        chk("ovf_drain_valid", v0, 0);

        clear();
        rdy0 = 0;
        CSN = 0;
        tick(6);
        send_bits(8'h01, 8);
        send_bits(8'h02, 7);
        MOSI = 0;
        tick(8);
        SCLK = 1;
        tick(3);
        chk("sim_valid_before", v0, 1);
        rdy0 = 1;
        tick(1);
        rdy0 = 0;
        chk("sim_valid_after", v0, 1);
        chk("sim_data", d0, 8'h02);
        tick(4);
        SCLK = 0;
        tick(4);
        CSN = 1;
        tick(20);
        chk("sim_ovf", n_ovf, 0);
        chk("sim_consumed", q0.size(), 1);
        if (q0.size() == 1) chk("sim_consumed_data", q0[0], 8'h01);
        rdy0 = 1;
        tick(4);
        chk("sim_drain_words", q0.size(), 2);

        clear();
        CSN = 0;
        tick(6);
        send_bits(8'h96, 4);
        chk("rstmid_busy", b0, 1);
        tick(2);
        rst = 1;
        tick(1);
        chk("rstmid_busy_rst", b0, 0);
        chk("rstmid_data_rst", d0, 0);
        chk("rstmid_valid_rst", v0, 0);
        tick(1);
        rst = 0;
        tick(6);
        for (int i = 4; i < 8; i++) send_bit(i == 5 || i == 6);
        tick(4);
        chk("rstmid_busy_hold", b0, 0);
        CSN = 1;
        tick(20);
        chk("rstmid_no_word", q0.size(), 0);
        chk("rstmid_no_word_lsb", q1.size(), 0);
        chk("rstmid_ferr", n_ferr, 0);
        clear();
        CSN = 0;
        tick(6);
        send_bits(8'h96, 8);
        tick(4);
        CSN = 1;
        tick(20);
        chk("after_rst_words", q0.size(), 1);
        if (q0.size() == 1) chk("after_rst_msb", q0[0], 8'h96);
        chk("after_rst_words_lsb", q1.size(), 1);
        if (q1.size() == 1) chk("after_rst_lsb", q1[0], 8'h69);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
